rx_data_fifo: RTL

//  Receive-side byte buffer directly downstream of the USB receiver control unit.

---
 rtl/rx_data_fifo.sv | 96 +++++++++
 1 files changed

// File: rtl/rx_data_fifo.sv
// Receive-side byte FIFO behind the USB RCU: first-word fall-through head,
// occupancy outputs and sticky overrun/underrun flags.
module rx_data_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_BITS  = 3,
    parameter int AFULL_LVL  = 6
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  w_enable,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  r_enable,
    input  logic                  clear_err,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_BITS:0]    count,
    output logic                  overrun,
    output logic                  underrun
);

    localparam logic [ADDR_BITS:0]   CNT_FULL  = (ADDR_BITS+1)'(DEPTH);
    localparam logic [ADDR_BITS:0]   CNT_AFULL = (ADDR_BITS+1)'(AFULL_LVL);
    localparam logic [ADDR_BITS:0]   CNT_ONE   = (ADDR_BITS+1)'(1);
    localparam logic [ADDR_BITS-1:0] PTR_ONE   = ADDR_BITS'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_BITS-1:0]  wptr;
    logic [ADDR_BITS-1:0]  rptr;

    logic wr_accept;
    logic rd_accept;
    logic overrun_evt;
    logic underrun_evt;

    assign empty       = (count == '0);
    assign full        = (count == CNT_FULL);
    assign almost_full = (count >= CNT_AFULL);
    assign r_data      = mem[rptr];

    // A full FIFO still takes a write when the head is popped in the same cycle.
    always_comb begin
        wr_accept    = w_enable && (!full || r_enable);
        rd_accept    = r_enable && !empty;
        overrun_evt  = w_enable && full && !r_enable;
        underrun_evt = r_enable && empty;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_accept) begin
            mem[wptr] <= w_data;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_accept) begin
                wptr <= wptr + PTR_ONE;
            end
            if (rd_accept) begin
                rptr <= rptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (wr_accept && !rd_accept) begin
            count <= count + CNT_ONE;
        end else if (rd_accept && !wr_accept) begin
            count <= count - CNT_ONE;
        end
    end

    // A new error event outranks clear_err arriving in the same cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            overrun  <= overrun_evt  || (overrun  && !clear_err);
            underrun <= underrun_evt || (underrun && !clear_err);
        end
    end

endmodule
